// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes operands LSB first, with the carry
// kept in a flop between cycles; the sum is reassembled in a shift register.

module addbit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [WIDTH-1:0]   r_opA;
    logic [WIDTH-1:0]   r_opB;
    logic [WIDTH-1:0]   r_sumsr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;
    logic               w_cellS;
    logic               w_cellCout;
    logic               w_lastBit;

    addbit u_addbit (
        .i_a    (r_opA[0]),
        .i_b    (r_opB[0]),
        .i_cin  (r_carry),
        .o_s    (w_cellS),
        .o_cout (w_cellCout)
    );

    assign w_lastBit = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (start) w_nextState = S_RUN;
            S_RUN:   if (w_lastBit) w_nextState = S_DONE;
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nextState;
    end

    // At the final bit r_carry still holds the carry into the MSB, so its xor with
    // the cell's carry-out is the signed overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opA   <= '0;
            r_opB   <= '0;
            r_sumsr <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_opA   <= a;
                        r_opB   <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_sumsr <= '0;
                    end
                end
                S_RUN: begin
                    r_sumsr <= {w_cellS, r_sumsr[WIDTH-1:1]};
                    r_opA   <= {1'b0, r_opA[WIDTH-1:1]};
                    r_opB   <= {1'b0, r_opB[WIDTH-1:1]};
                    r_carry <= w_cellCout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_lastBit) begin
                        r_cout <= w_cellCout;
                        r_ovf  <= w_cellCout ^ r_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign sum  = r_sumsr;
    assign cout = r_cout;
    assign ovf  = r_ovf;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vector table, timing/corner sequences
// and random operands checked against an arithmetic reference model.

module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int nAssert = 0;
    int nFail   = 0;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic [W-1:0] expSum;
        logic         expCout;
        logic         expOvf;
    } vec_t;

    vec_t vecs[4];

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nAssert++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference: plain integer addition; signed overflow when both operands share a
    // sign that the result does not.
    task automatic model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                         output logic [W-1:0] s, output logic c, output logic v);
        int full;
        full = int'(ia) + int'(ib) + int'(icin);
        s = W'(full);
        c = (full >= (1 << W));
        v = (ia[W-1] == ib[W-1]) && (s[W-1] != ia[W-1]);
    endtask

    // Starts one operation in the current (idle) cycle and stops in the done cycle.
    task automatic applyStimulus(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                                 output int lat, output int busyCnt, output logic seen);
        a = ia; b = ib; cin = icin; start = 1'b1;
        lat = 0; busyCnt = 0; seen = 1'b0;
        stepCycle();
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (busy) busyCnt++;
            if (done) begin
                lat  = k;
                seen = 1'b1;
                break;
            end
            stepCycle();
        end
        checkOutput("doneSeen", 32'(seen), 32'd1);
    endtask

    initial begin
        int           lat, busyCnt, doneCnt;
        logic         seen;
        logic [W-1:0] mS;
        logic         mC, mV;
        int           doneAt[$];

        vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        stepCycle();
        stepCycle();
        rst = 1'b0;
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetSum",  32'(sum),  32'd0);
        checkOutput("resetCout", 32'(cout), 32'd0);
        checkOutput("resetOvf",  32'(ovf),  32'd0);

        // Directed vectors, including latency and busy length
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].va, vecs[i].vb, vecs[i].vcin, lat, busyCnt, seen);
            checkOutput("vecLatency", 32'(lat), 32'd9);
            checkOutput("vecBusyCnt", 32'(busyCnt), 32'd9);
            checkOutput("vecSum",  32'(sum),  32'(vecs[i].expSum));
            checkOutput("vecCout", 32'(cout), 32'(vecs[i].expCout));
            checkOutput("vecOvf",  32'(ovf),  32'(vecs[i].expOvf));
            stepCycle();
            checkOutput("vecIdleBusy", 32'(busy), 32'd0);
        end

        // Starts and operand changes during RUN (cycle 3) and DONE (cycle 9) are ignored
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        stepCycle();
        doneCnt = 0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 3 || k == 9) begin
                start = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'(($urandom));
            end else begin
                start = 1'b0;
            end
            if (done) begin
                doneCnt++;
                checkOutput("ignDoneCycle", 32'(k), 32'd9);
            end
            if (k >= 9) begin
                checkOutput("ignSum", 32'(sum), 32'h46);
                checkOutput("ignCout", 32'(cout), 32'd0);
            end
            if (k >= 10) checkOutput("ignIdleBusy", 32'(busy), 32'd0);
            stepCycle();
        end
        start = 1'b0;
        checkOutput("ignDoneCount", 32'(doneCnt), 32'd1);

        // Reset in cycle 4 of an op discards it
        a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
        stepCycle();
        start = 1'b0;
        for (int k = 1; k < 4; k++) stepCycle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstDone", 32'(done), 32'd0);
        checkOutput("midRstSum",  32'(sum),  32'd0);
        checkOutput("midRstCout", 32'(cout), 32'd0);
        checkOutput("midRstOvf",  32'(ovf),  32'd0);
        doneCnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) doneCnt++;
            stepCycle();
        end
        checkOutput("midRstNoDone", 32'(doneCnt), 32'd0);

        applyStimulus(8'h01, 8'h01, 1'b0, lat, busyCnt, seen);
        checkOutput("postRstLatency", 32'(lat), 32'd9);
        checkOutput("postRstSum", 32'(sum), 32'h02);
        stepCycle();

        // Start held high: one op every WIDTH+2 cycles
        a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
        stepCycle();
        for (int k = 1; k <= 35; k++) begin
            if (done) begin
                doneAt.push_back(k);
                checkOutput("b2bSum", 32'(sum), 32'h33);
            end
            stepCycle();
        end
        start = 1'b0;
        checkOutput("b2bDoneCount", 32'(doneAt.size()), 32'd3);
        if (doneAt.size() == 3) begin
            checkOutput("b2bDone0", 32'(doneAt[0]), 32'd9);
            checkOutput("b2bDone1", 32'(doneAt[1]), 32'd19);
            checkOutput("b2bDone2", 32'(doneAt[2]), 32'd29);
        end
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;

        // Random operands against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            model(ra, rb, rc, mS, mC, mV);
            applyStimulus(ra, rb, rc, lat, busyCnt, seen);
            checkOutput("rndLatency", 32'(lat), 32'd9);
            checkOutput("rndSum",  32'(sum),  32'(mS));
            checkOutput("rndCout", 32'(cout), 32'(mC));
            checkOutput("rndOvf",  32'(ovf),  32'(mV));
            stepCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
